fetch_prefetch_unit: RTL

Instruction-fetch front end that sits directly upstream of the sequential CPU core's decode/execute logic. Issues in-order word requests to instruction memory over a valid/ready channel and buffers returned instructions with their PCs in a small prefetch queue. Hands instructions to the core over a valid/ready handshake. Handles taken-branch redirects by flushing and discarding stale responses, and stops fetching on the all-zero halt instruction.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_prefetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and the prefetch queue entry type for the fetch front end.
package fetch_pkg;
    localparam int                XLEN      = 64;
    localparam int                INST_W    = 32;
    localparam int                ENTRY_W   = XLEN + INST_W;
    localparam logic [INST_W-1:0] HALT_INST = 32'h0;
    localparam logic [XLEN-1:0]   PC_INC    = 64'd4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: small synchronous FIFO of {pc, inst} entries with flush.
// Push into a full queue is accepted only when a pop frees a slot in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [ENTRY_W-1:0]         wdata_i,
    output logic [ENTRY_W-1:0]         rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer, occupancy and storage update; flush empties the queue and wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: in-order imem requests, prefetch queue, redirect and halt.
// Request credit = queue occupancy + live (non-discarded) in-flight requests, so a
// response always has a queue slot waiting for it.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 4,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [XLEN-1:0]   imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [INST_W-1:0] imem_rsp_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_data_o,
    output logic [XLEN-1:0]   inst_pc_o,
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              halted_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   discard_q, discard_d;
    logic            halted_q, halted_d;

    logic [CW-1:0]   q_count;
    logic            q_full, q_empty;
    fetch_entry_t    q_head, q_wdata;
    logic [OW-1:0]   live;
    logic [SW-1:0]   credit_used;
    logic            req_fire, pop, push, flush, redirect, halt_now;

    assign live        = outst_q - discard_q;
    assign credit_used = SW'(q_count) + SW'(live);
    assign redirect    = redirect_valid_i && !halted_q;

    // Reset gates the request combinationally so it drops without waiting for a clock.
    assign imem_req_valid_o = reset_ni && !halted_q && !redirect_valid_i &&
                              (credit_used < SW'(DEPTH)) &&
                              (outst_q < OW'(MAX_OUTSTANDING));
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign inst_valid_o = !q_empty && !halted_q;
    assign inst_data_o  = q_head.inst;
    assign inst_pc_o    = q_head.pc;
    assign halted_o     = halted_q;
    assign pop          = inst_valid_o && inst_ready_i;
    assign halt_now     = pop && (q_head.inst == HALT_INST);
    assign flush        = redirect || halt_now;

    // Stale responses (discard > 0), and anything arriving once halted or while flushing, are dropped.
    assign push    = imem_rsp_valid_i && (discard_q == '0) && !halted_q && !flush;
    assign q_wdata = '{pc: rsp_pc_q, inst: imem_rsp_data_i};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (reset_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (q_wdata),
        .rdata_o (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Next PCs, in-flight counters and halt flag; a redirect discards whatever is still in flight.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        halted_d   = halted_q || halt_now;
        outst_d    = outst_q + OW'(req_fire) - OW'(imem_rsp_valid_i);
        discard_d  = discard_q;
        if (imem_rsp_valid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;
        if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
        if (push)     rsp_pc_d   = rsp_pc_q + PC_INC;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc_i);
            rsp_pc_d   = word_align(redirect_pc_i);
            discard_d  = outst_d;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
        end
    end

    // A response push must always find room in the queue.
    assert property (@(posedge clk_i) disable iff (!reset_ni) push |-> (!q_full || pop));
endmodule
